// File: rtl/amm_mem_responder_pkg.sv
// rtl/amm_mem_responder_pkg.sv - shared widths, addressing mode and FSM state type for the AMM responder
package amm_mem_responder_pkg;

  localparam int AMM_ADDR_W  = 32;
  localparam int AMM_DATA_W  = 32;
  localparam int AMM_BURST_W = 8;
  localparam int DATA_B_W    = AMM_DATA_W / 8;
  localparam int ADDR_B_W    = 2;
  localparam     ADDR_TYPE   = "BYTE";

  localparam int RESP_MEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } resp_state_t;

endpackage

// File: rtl/amm_mem_responder_if.sv
// rtl/amm_mem_responder_if.sv - Avalon-MM burst bus between the checker transmitter and the responder
interface amm_mem_responder_if;
  import amm_mem_responder_pkg::*;

  logic [AMM_ADDR_W-1:0]  address;
  logic                   read;
  logic                   write;
  logic [AMM_DATA_W-1:0]  writedata;
  logic [AMM_BURST_W-1:0] burstcount;
  logic [DATA_B_W-1:0]    byteenable;
  logic                   waitrequest;
  logic                   readdatavalid;
  logic [AMM_DATA_W-1:0]  readdata;

  modport master (
    output address, read, write, writedata, burstcount, byteenable,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  address, read, write, writedata, burstcount, byteenable,
    output waitrequest, readdatavalid, readdata
  );

endinterface

// File: rtl/amm_resp_ram.sv
// rtl/amm_resp_ram.sv - single-port byte-writable RAM with one-cycle registered read
module amm_resp_ram #(
  parameter int ADDR_W = 10,
  parameter int BYTES  = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [BYTES-1:0]     be,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [8*BYTES-1:0]   wdata,
  input  logic                 re,
  output logic [8*BYTES-1:0]   rdata
);

  logic [8*BYTES-1:0] mem [2**ADDR_W];

  // Registered read and per-byte write; contents are deliberately never reset
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int b = 0; b < BYTES; b++) begin
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/amm_mem_responder.sv
// rtl/amm_mem_responder.sv - Avalon-MM burst memory slave with fixed read latency and stall injection
module amm_mem_responder
  import amm_mem_responder_pkg::*;
#(
  parameter int MEM_ADDR_W   = RESP_MEM_ADDR_W,
  parameter int READ_LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_en_i,
  amm_mem_responder_if.slave amm,
  output logic              protocol_err_o
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WR   = WR_BURST;
  localparam logic [1:0] S_RD   = RD_BURST;

  logic [1:0]             state, state_nx;
  logic [AMM_BURST_W-1:0] remaining, bc_eff;
  logic [MEM_ADDR_W-1:0]  beat_addr, cmd_idx, ram_addr;
  logic [7:0]             lfsr;
  logic                   waitreq, accept, both_cmd, last_beat;
  logic                   idle_acc, idle_wr, idle_rd, burst_wr, rd_issue, ram_we;
  logic                   ram_v, out_v;
  logic [AMM_DATA_W-1:0]  ram_q, out_d;
  wire                    unused_addr = ^amm.address;

  assign cmd_idx   = (ADDR_TYPE == "BYTE") ? amm.address[ADDR_B_W +: MEM_ADDR_W]
                                           : amm.address[MEM_ADDR_W-1:0];
  assign bc_eff    = (amm.burstcount == '0) ? AMM_BURST_W'(1) : amm.burstcount;
  assign accept    = (amm.read | amm.write) & ~waitreq;
  assign both_cmd  = amm.read & amm.write;
  assign last_beat = (remaining == AMM_BURST_W'(1));
  assign idle_acc  = (state == S_IDLE) & accept & ~both_cmd;
  assign idle_wr   = idle_acc & amm.write;
  assign idle_rd   = idle_acc & amm.read;
  assign burst_wr  = (state == S_WR) & amm.write & ~waitreq;
  assign rd_issue  = idle_rd | (state == S_RD);
  assign ram_we    = idle_wr | burst_wr;
  assign ram_addr  = (state == S_IDLE) ? cmd_idx : beat_addr;

  amm_resp_ram #(.ADDR_W(MEM_ADDR_W), .BYTES(DATA_B_W)) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .be    (amm.byteenable),
    .addr  (ram_addr),
    .wdata (amm.writedata),
    .re    (rd_issue),
    .rdata (ram_q)
  );

  // Next-state decision: bursts longer than one beat leave IDLE, last beat returns
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (idle_wr && bc_eff > AMM_BURST_W'(1)) state_nx = S_WR;
        if (idle_rd && bc_eff > AMM_BURST_W'(1)) state_nx = S_RD;
      end
      S_WR:    if (burst_wr && last_beat) state_nx = S_IDLE;
      S_RD:    if (last_beat) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM, beat counter and address counter (address wraps naturally at MEM_ADDR_W bits)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      remaining <= '0;
      beat_addr <= '0;
    end else begin
      state <= state_nx;
      if (idle_wr || idle_rd) begin
        remaining <= bc_eff - AMM_BURST_W'(1);
        beat_addr <= cmd_idx + MEM_ADDR_W'(1);
      end else if (burst_wr || state == S_RD) begin
        remaining <= remaining - AMM_BURST_W'(1);
        beat_addr <= beat_addr + MEM_ADDR_W'(1);
      end
    end
  end

  // Free-running LFSR and registered waitrequest: forced high while read beats are still issuing
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lfsr    <= 8'hFF;
      waitreq <= 1'b1;
    end else begin
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      waitreq <= (state_nx == S_RD) ? 1'b1 : (stall_en_i & lfsr[1] & lfsr[0]);
    end
  end

  // Sticky protocol error: simultaneous read/write, zero burstcount, or read inside a write burst
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      protocol_err_o <= 1'b0;
    end else if (state == S_IDLE && accept && (both_cmd || amm.burstcount == '0)) begin
      protocol_err_o <= 1'b1;
    end else if (state == S_WR && amm.read && !waitreq) begin
      protocol_err_o <= 1'b1;
    end
  end

  // Tracks which RAM output cycles carry an issued read beat
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ram_v <= 1'b0;
    else          ram_v <= rd_issue;
  end

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign out_v = ram_v;
      assign out_d = ram_q;
    end else begin : g_pipe
      logic [READ_LATENCY-2:0] v;
      logic [AMM_DATA_W-1:0]   d [READ_LATENCY-1];
      // Extra latency stages after the RAM; reset drops any beats in flight
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          v <= '0;
          for (int i = 0; i < READ_LATENCY - 1; i++) d[i] <= '0;
        end else begin
          v[0] <= ram_v;
          d[0] <= ram_q;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
          end
        end
      end
      assign out_v = v[READ_LATENCY-2];
      assign out_d = d[READ_LATENCY-2];
    end
  endgenerate

  assign amm.waitrequest   = waitreq;
  assign amm.readdatavalid = out_v;
  assign amm.readdata      = out_v ? out_d : '0;

endmodule

// File: tb/tb_amm_mem_responder.sv
// tb/tb_amm_mem_responder.sv - self-checking bench for amm_mem_responder with a word-array memory model
module tb_amm_mem_responder;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic stall_en;
  logic perr;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [31:0] mdl [16];
  logic [31:0] wdat [16];
  logic [3:0]  wbe [16];
  logic [31:0] exp_q [$];

  amm_mem_responder_if bus ();

  amm_mem_responder #(.MEM_ADDR_W(4), .READ_LATENCY(LAT)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .stall_en_i     (stall_en),
    .amm            (bus),
    .protocol_err_o (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Called at a negedge with the command driven; returns at the negedge after the accepting edge
  task automatic wait_accept(input string tag);
    int k = 0;
    while (bus.waitrequest !== 1'b0 && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(k < 64), 32'd1);
    @(negedge clk);
  endtask

  task automatic wr_burst(input logic [31:0] a, input int n, input logic [7:0] bc);
    int idx = int'(a[5:2]);
    for (int i = 0; i < n; i++) begin
      bus.write      = 1'b1;
      bus.address    = a;
      bus.burstcount = bc;
      bus.writedata  = wdat[i];
      bus.byteenable = wbe[i];
      wait_accept("wr_accept");
      mdl[(idx + i) % 16] = merge(mdl[(idx + i) % 16], wdat[i], wbe[i]);
    end
    bus.write = 1'b0;
  endtask

  task automatic rd_start(input logic [31:0] a, input logic [7:0] bc);
    bus.read       = 1'b1;
    bus.address    = a;
    bus.burstcount = bc;
    wait_accept("rd_accept");
    bus.read = 1'b0;
  endtask

  // Checks every cycle T+1..T+LAT+n: forced waitrequest, exact valid window, data order
  task automatic rd_burst(input logic [31:0] a, input int n);
    logic [7:0] bc = n[7:0];
    rd_start(a, bc);
    for (int j = 1; j <= LAT + n; j++) begin
      if (j < n) chk("rd_waitreq", 32'(bus.waitrequest), 32'd1);
      if (j >= LAT && j < LAT + n) begin
        chk("rd_valid", 32'(bus.readdatavalid), 32'd1);
        chk("rd_data", bus.readdata, exp_q.pop_front());
      end else begin
        chk("rd_novalid", 32'(bus.readdatavalid), 32'd0);
      end
      @(negedge clk);
    end
  endtask

  task automatic push_model(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mdl[(int'(a[5:2]) + i) % 16]);
  endtask

  initial begin
    rst_n          = 1'b0;
    stall_en       = 1'b0;
    bus.address    = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
    bus.burstcount = 8'd1;
    bus.byteenable = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_waitreq", 32'(bus.waitrequest), 32'd1);
    chk("rst_rdvalid", 32'(bus.readdatavalid), 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_waitreq", 32'(bus.waitrequest), 32'd0);

    // Fill all words so later random reads never hit uninitialised RAM
    for (int i = 0; i < 16; i++) begin
      wdat[i] = $urandom;
      wbe[i]  = 4'hF;
    end
    wr_burst(32'h0, 16, 8'd16);
    push_model(32'h0, 16);
    rd_burst(32'h0, 16);

    // Single write then single read
    wdat[0] = 32'hA5A5A5A5; wbe[0] = 4'hF;
    wr_burst(32'h10, 1, 8'd1);
    exp_q.push_back(32'hA5A5A5A5);
    rd_burst(32'h10, 1);

    // Partial byte-enable overwrite
    wdat[0] = 32'h11111111; wbe[0] = 4'hF;
    wr_burst(32'h20, 1, 8'd1);
    wdat[0] = 32'hFFFFFFFF; wbe[0] = 4'b0101;
    wr_burst(32'h20, 1, 8'd1);
    exp_q.push_back(32'h11FF11FF);
    rd_burst(32'h20, 1);

    // Bursts with stall injection enabled
    stall_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'(i + 1);
      wbe[i]  = 4'hF;
    end
    wr_burst(32'h0, 4, 8'd4);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    rd_burst(32'h0, 4);
    stall_en = 1'b0;

    // Address wrap from word 15 to word 0
    wdat[0] = 32'hAA; wdat[1] = 32'hBB; wbe[0] = 4'hF; wbe[1] = 4'hF;
    wr_burst(32'h3C, 2, 8'd2);
    exp_q.push_back(32'hBB);
    rd_burst(32'h0, 1);
    exp_q.push_back(32'hAA);
    exp_q.push_back(32'hBB);
    rd_burst(32'h3C, 2);
    chk("perr_clean", 32'(perr), 32'd0);

    // Randomised bursts against the model
    for (int it = 0; it < 20; it++) begin
      int          nw = $urandom_range(1, 4);
      int          nr = $urandom_range(1, 5);
      logic [31:0] aw = $urandom;
      logic [31:0] ar = $urandom;
      stall_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < nw; i++) begin
        wdat[i] = $urandom;
        wbe[i]  = 4'($urandom);
      end
      wr_burst(aw, nw, nw[7:0]);
      push_model(ar, nr);
      rd_burst(ar, nr);
    end
    stall_en = 1'b0;
    chk("perr_after_random", 32'(perr), 32'd0);

    // Zero burstcount: one beat only, sticky error
    wdat[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
    wr_burst(32'h08, 1, 8'd0);
    chk("perr_bc0", 32'(perr), 32'd1);
    push_model(32'h08, 2);
    rd_burst(32'h08, 2);

    // Simultaneous read and write: no RAM change
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 32'h04;
    bus.burstcount = 8'd1;
    bus.writedata  = 32'h0BADF00D;
    bus.byteenable = 4'hF;
    wait_accept("rw_accept");
    bus.read  = 1'b0;
    bus.write = 1'b0;
    chk("perr_rw", 32'(perr), 32'd1);
    push_model(32'h04, 1);
    rd_burst(32'h04, 1);

    // Reset in the middle of a read burst
    rd_start(32'h0, 8'd4);
    @(negedge clk);
    @(negedge clk);
    chk("mid_beat0_valid", 32'(bus.readdatavalid), 32'd1);
    @(negedge clk);
    chk("mid_beat1_valid", 32'(bus.readdatavalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdvalid", 32'(bus.readdatavalid), 32'd0);
    chk("mid_rst_waitreq", 32'(bus.waitrequest), 32'd1);
    @(negedge clk);
    chk("mid_rst_hold_waitreq", 32'(bus.waitrequest), 32'd1);
    chk("mid_rst_perr", 32'(perr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_release_waitreq", 32'(bus.waitrequest), 32'd0);
    chk("mid_release_rdvalid", 32'(bus.readdatavalid), 32'd0);
    push_model(32'h14, 3);
    rd_burst(32'h14, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
